// File: rtl/display_pkg.sv
// Shared definitions for the display datapath: BCD digit width, the
// sequential converter state type and a helper that sizes a BCD field.
package display_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } dd_state_t;

  // Decimal digits needed to show any BIN_W-bit unsigned value:
  // ceil(binW * log10(2)), with log10(2) approximated as 0.30103.
  function automatic int digitsNeeded(input int binW);
    return (binW * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Single BCD correction cell for shift-and-add-3: a digit of 5 or more
// gets 3 added so that the following left shift carries into the next digit.
module bcd_add3_digit (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Conditional add-3 correction ahead of the shift
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/seq_double_dabble.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with start/busy/done handshake, sticky overflow and a leading-zero mask.
module seq_double_dabble
  import display_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          overflow,
  output logic [DIGITS-1:0]             blank_mask
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  dd_state_t          state_q;
  logic [BIN_W-1:0]   shreg_q;
  logic [SCR_W-1:0]   scratch_q;
  logic [CNT_W-1:0]   count_q;
  logic               ovfSticky_q;
  logic               busy_q;
  logic               done_q;
  logic [SCR_W-1:0]   bcdOut_q;
  logic               overflow_q;
  logic [DIGITS-1:0]  blankMask_q;

  logic [SCR_W-1:0]   adjusted;
  logic [SCR_W-1:0]   scratch_d;
  logic               ovfSticky_d;
  logic [DIGITS-1:0]  blankMask_d;
  logic               upperZero;

  // One add-3 correction cell per BCD digit of the scratch register
  for (genvar g = 0; g < DIGITS; g++) begin : gen_add3
    bcd_add3_digit u_add3 (
      .digit_i (scratch_q[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .digit_o (adjusted[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  // Shift the corrected scratch left, pulling in the next binary bit;
  // a 1 leaving the top digit means the value no longer fits
  always_comb begin
    scratch_d   = {adjusted[SCR_W-2:0], shreg_q[BIN_W-1]};
    ovfSticky_d = ovfSticky_q | adjusted[SCR_W-1];
  end

  // Leading-zero mask from the top digit down; the units digit always shows
  always_comb begin
    blankMask_d = '0;
    upperZero   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upperZero      = upperZero & (scratch_d[BCD_DIGIT_W*i +: BCD_DIGIT_W] == '0);
      blankMask_d[i] = upperZero;
    end
  end

  // Control FSM and datapath registers with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      scratch_q   <= '0;
      count_q     <= '0;
      ovfSticky_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bcdOut_q    <= '0;
      overflow_q  <= 1'b0;
      blankMask_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shreg_q     <= bin_in;
            scratch_q   <= '0;
            ovfSticky_q <= 1'b0;
            count_q     <= '0;
            busy_q      <= 1'b1;
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q   <= scratch_d;
          shreg_q     <= {shreg_q[BIN_W-2:0], 1'b0};
          ovfSticky_q <= ovfSticky_d;
          count_q     <= count_q + CNT_W'(1);
          if (count_q == LAST_CNT) begin
            bcdOut_q    <= scratch_d;
            overflow_q  <= ovfSticky_d;
            blankMask_q <= blankMask_d;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign bcd_out    = bcdOut_q;
  assign overflow   = overflow_q;
  assign blank_mask = blankMask_q;

endmodule
